if_fetch: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the fetch PC and a direct-mapped instruction cache, and on a miss it reads the 32-bit instruction byte-serially through the 8-bit memory-controller port. It presents one fetched instruction at a time to the if_id register. The id stage redirects it with `jump_flag`/`jump_addr`, and ctrl holds it with `stall`.

---
 rtl/if_fetch.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC and a direct-mapped one-instruction-per-line
// I-cache, refilling misses byte-serially over the 8-bit memory-controller port.
module if_fetch #(
    parameter int unsigned          ADDR_LEN       = 32,
    parameter int unsigned          INST_LEN       = 32,
    parameter int unsigned          ICACHE_ENTRIES = 64,
    parameter logic [ADDR_LEN-1:0]  RESET_PC       = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jump_flag,
    input  logic [ADDR_LEN-1:0] jump_addr,
    input  logic                mem_busy,
    input  logic [7:0]          mem_data,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                if_valid,
    output logic [ADDR_LEN-1:0] if_pc,
    output logic [INST_LEN-1:0] if_inst
);

    localparam int unsigned IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TAG_W = ADDR_LEN - 2 - IDX_W;

    typedef enum logic {StIdle, StMiss} state_e;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]          ic_q, ic_d;
    logic                issued_q, issued_d;  // all four byte requests accepted
    logic [2:0]          rc_q, rc_d;
    logic                acc_q, acc_d;        // a request was accepted last cycle
    logic [23:0]         buf_q, buf_d;        // bytes 0..2 of the line being filled

    logic                slot_valid_q, slot_valid_d;
    logic [ADDR_LEN-1:0] slot_pc_q, slot_pc_d;
    logic [INST_LEN-1:0] slot_inst_q, slot_inst_d;

    logic [ICACHE_ENTRIES-1:0] line_valid_q;
    logic [TAG_W-1:0]          line_tag_q  [ICACHE_ENTRIES];
    logic [INST_LEN-1:0]       line_data_q [ICACHE_ENTRIES];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                slot_free;
    logic                load;
    logic [INST_LEN-1:0] load_inst;
    logic                wr_en;
    logic                req_c;
    logic [ADDR_LEN-1:0] addr_c;
    logic [INST_LEN-1:0] fill_word;

    assign idx       = fetch_pc_q[IDX_W+1:2];
    assign tag       = fetch_pc_q[ADDR_LEN-1:IDX_W+2];
    assign hit       = line_valid_q[idx] && (line_tag_q[idx] == tag);
    assign slot_free = !slot_valid_q || !stall;
    assign fill_word = {mem_data, buf_q};

    // Next-state logic: redirect first, then hit delivery or byte-serial refill.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        ic_d         = ic_q;
        issued_d     = issued_q;
        rc_d         = rc_q;
        acc_d        = 1'b0;
        buf_d        = buf_q;
        load         = 1'b0;
        load_inst    = '0;
        wr_en        = 1'b0;
        req_c        = 1'b0;
        addr_c       = '0;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_inst_d  = slot_inst_q;

        if (jump_flag) begin
            // In-flight bytes are dropped simply by clearing acc/rc.
            state_d    = StIdle;
            fetch_pc_d = jump_addr;
            ic_d       = '0;
            issued_d   = 1'b0;
            rc_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        if (slot_free) begin
                            load       = 1'b1;
                            load_inst  = line_data_q[idx];
                            fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
                        end
                    end else begin
                        req_c  = 1'b1;
                        addr_c = fetch_pc_q;
                        if (!mem_busy) begin
                            state_d  = StMiss;
                            ic_d     = 2'd1;
                            issued_d = 1'b0;
                            rc_d     = '0;
                            acc_d    = 1'b1;
                        end
                    end
                end
                StMiss: begin
                    if (!issued_q) begin
                        req_c  = 1'b1;
                        addr_c = fetch_pc_q + {{(ADDR_LEN-2){1'b0}}, ic_q};
                        if (!mem_busy) begin
                            ic_d  = ic_q + 2'd1;
                            acc_d = 1'b1;
                            if (ic_q == 2'd3) issued_d = 1'b1;
                        end
                    end
                    if (acc_q) begin
                        rc_d = rc_q + 3'd1;
                        unique case (rc_q[1:0])
                            2'd0:    buf_d[7:0]   = mem_data;
                            2'd1:    buf_d[15:8]  = mem_data;
                            2'd2:    buf_d[23:16] = mem_data;
                            default: ;
                        endcase
                        if (rc_q == 3'd3) begin
                            wr_en    = 1'b1;
                            state_d  = StIdle;
                            ic_d     = '0;
                            issued_d = 1'b0;
                            rc_d     = '0;
                            if (slot_free) begin
                                load       = 1'b1;
                                load_inst  = fill_word;
                                fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        if (jump_flag) begin
            slot_valid_d = 1'b0;
        end else if (load) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = fetch_pc_q;
            slot_inst_d  = load_inst;
        end else if (slot_free) begin
            slot_valid_d = 1'b0;
        end
    end

    // Fetch control and output-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            ic_q         <= '0;
            issued_q     <= 1'b0;
            rc_q         <= '0;
            acc_q        <= 1'b0;
            buf_q        <= '0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            ic_q         <= ic_d;
            issued_q     <= issued_d;
            rc_q         <= rc_d;
            acc_q        <= acc_d;
            buf_q        <= buf_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_inst_q  <= slot_inst_d;
        end
    end

    // Line valid bits; only these need reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (wr_en) begin
            line_valid_q[idx] <= 1'b1;
        end
    end

    // Line tag and data storage, written when the fourth byte arrives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_tag_q[idx]  <= tag;
            line_data_q[idx] <= fill_word;
        end
    end

    // Memory port is forced quiet while reset is held.
    assign mem_req  = req_c && !rst;
    assign mem_addr = rst ? '0 : addr_c;
    assign if_valid = slot_valid_q;
    assign if_pc    = slot_pc_q;
    assign if_inst  = slot_inst_q;

endmodule
